// File: rtl/alu_operand_seq.sv
// Operand-entry front end for the board ALU: debounces next/back/clear, steps the
// user through A, B and opcode entry, strobes the ALU, and holds its result.
module alu_operand_seq #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [4:0]  button,
  input  logic [3:0]  result_in,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        ops_valid,
  output logic [3:0]  result_q,
  output logic        result_valid,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 16'd1);

  logic [2:0] press;
  logic [1:0] settle_reg;
  logic       unused_inputs;

  assign unused_inputs = ^{sw[15:11], button[4:3]};

  // Marks when the synchronisers carry post-reset samples of the raw buttons.
  always_ff @(posedge clk) begin
    if (rst) settle_reg <= 2'b00;
    else     settle_reg <= {settle_reg[0], 1'b1};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic             sync1_reg, sync2_reg, deb_reg, deb_d_reg, block_reg, press_reg;
      logic [CNT_W-1:0] cnt_reg;

      // block_reg suppresses the press from a button held through reset until
      // the synchronised level has been seen low once.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          block_reg <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= button[gi];
          sync2_reg <= sync1_reg;
          deb_d_reg <= deb_reg;
          press_reg <= deb_reg & ~deb_d_reg & ~block_reg;
          if (settle_reg[1] && !sync2_reg) block_reg <= 1'b0;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_MAX) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic   nx, bk, clr;
  state_t state_reg, state_next;
  logic [3:0] a_reg, a_next, b_reg, b_next, rq_reg, rq_next;
  logic [2:0] op_reg, op_next;
  logic       rv_reg, rv_next;

  assign nx  = press[0];
  assign bk  = press[1];
  assign clr = press[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_A;
      a_reg     <= 4'd0;
      b_reg     <= 4'd0;
      op_reg    <= 3'd0;
      rq_reg    <= 4'd0;
      rv_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      rq_reg    <= rq_next;
      rv_reg    <= rv_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    rq_next    = rq_reg;
    rv_next    = rv_reg;
    if (clr) begin
      state_next = S_A;
      a_next     = 4'd0;
      b_next     = 4'd0;
      op_next    = 3'd0;
      rq_next    = 4'd0;
      rv_next    = 1'b0;
    end else begin
      case (state_reg)
        S_A: begin
          if (!bk && nx) begin
            a_next     = sw[3:0];
            state_next = S_B;
          end
        end
        S_B: begin
          if (bk) begin
            state_next = S_A;
          end else if (nx) begin
            b_next     = sw[7:4];
            state_next = S_OP;
          end
        end
        S_OP: begin
          if (bk) begin
            state_next = S_B;
          end else if (nx) begin
            op_next    = sw[10:8];
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          rq_next    = result_in;
          rv_next    = 1'b1;
          state_next = S_SHOW;
        end
        S_SHOW: begin
          // back keeps the operands so only the opcode needs re-entering
          if (bk) begin
            state_next = S_OP;
            rv_next    = 1'b0;
          end else if (nx) begin
            state_next = S_A;
            rv_next    = 1'b0;
          end
        end
        default: state_next = S_A;
      endcase
    end
  end

  assign alu_a        = a_reg;
  assign alu_b        = b_reg;
  assign alu_op       = op_reg;
  assign result_q     = rq_reg;
  assign result_valid = rv_reg;
  assign ops_valid    = (state_reg == S_EXEC);
  assign state_o      = state_reg;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq: a scoreboard queue holds the expected
// operands/result of each execute and a monitor checks them on ops_valid.
module tb_alu_operand_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  button;
  logic [3:0]  result_in;
  logic [3:0]  alu_a, alu_b, result_q;
  logic [2:0]  alu_op, state_o;
  logic        ops_valid, result_valid;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // ALU model: A+B, truncated to 4 bits
  assign result_in = alu_a + alu_b;

  alu_operand_seq #(.DEB_CYCLES(16'd4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sw(sw), .button(button), .result_in(result_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ops_valid(ops_valid),
    .result_q(result_q), .result_valid(result_valid), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.op  = op;
    e.res = 4'(a + b);
    return e;
  endfunction

  // Raise the buttons in mask for hold cycles, release, then let debounce settle.
  task automatic press_for(input logic [2:0] mask, input int hold);
    button[2:0] = mask;
    tick(hold);
    button[2:0] = 3'b000;
    tick(12);
    $display("press mask=%b hold=%0d -> state=%0d a=%0h b=%0h op=%0h rv=%0b",
             mask, hold, state_o, alu_a, alu_b, alu_op, result_valid);
  endtask

  // next press, held 10 cycles; the step must land exactly on edge 7 after the rise.
  task automatic press_timed(input logic [2:0] st_new, input string tag);
    logic [2:0] st_old;
    st_old    = state_o;
    button[0] = 1'b1;
    tick(7);
    chk({tag, "_edge6"}, 16'(state_o), 16'(st_old));
    tick(1);
    chk({tag, "_edge7"}, 16'(state_o), 16'(st_new));
    tick(2);
    button[0] = 1'b0;
    tick(10);
    $display("timed next -> state=%0d a=%0h b=%0h op=%0h", state_o, alu_a, alu_b, alu_op);
  endtask

  // Scoreboard monitor: every ops_valid must match a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ops_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ops_valid", 16'(ops_valid), 16'd0);
        end else begin
          e = exp_q.pop_front();
          chk("exec_alu_a", 16'(alu_a), 16'(e.a));
          chk("exec_alu_b", 16'(alu_b), 16'(e.b));
          chk("exec_alu_op", 16'(alu_op), 16'(e.op));
          @(posedge clk);
          #1;
          chk("exec_result_q", 16'(result_q), 16'(e.res));
          chk("exec_result_valid", 16'(result_valid), 16'd1);
          chk("exec_single_cycle", 16'(ops_valid), 16'd0);
          chk("exec_state_show", 16'(state_o), 16'd4);
          $display("exec a=%0h b=%0h op=%0h result_q=%0h", alu_a, alu_b, alu_op, result_q);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    sw     = 16'h0000;
    button = 5'b00000;
    tick(3);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_alu_b", 16'(alu_b), 16'd0);
    chk("rst_alu_op", 16'(alu_op), 16'd0);
    chk("rst_result_q", 16'(result_q), 16'd0);
    chk("rst_result_valid", 16'(result_valid), 16'd0);
    chk("rst_ops_valid", 16'(ops_valid), 16'd0);
    chk("rst_state", 16'(state_o), 16'd0);
    rst = 1'b0;
    tick(100);
    chk("idle_state", 16'(state_o), 16'd0);

    // Full entry sequence with timed latency
    sw = 16'h0573;
    press_timed(3'd1, "next_a");
    chk("load_a", 16'(alu_a), 16'd3);
    press_timed(3'd2, "next_b");
    chk("load_b", 16'(alu_b), 16'd7);
    exp_q.push_back(mk(4'd3, 4'd7, 3'd5));
    press_timed(3'd3, "next_op");
    chk("show_state", 16'(state_o), 16'd4);
    chk("show_result_q", 16'(result_q), 16'hA);
    chk("show_result_valid", 16'(result_valid), 16'd1);

    // Switches ignored outside the loading edges
    sw = 16'hFFFF;
    tick(5);
    chk("hold_a", 16'(alu_a), 16'd3);
    chk("hold_b", 16'(alu_b), 16'd7);
    chk("hold_op", 16'(alu_op), 16'd5);
    sw = 16'h0573;

    // Glitch then long hold
    press_for(3'b001, 3);
    chk("glitch_state", 16'(state_o), 16'd4);
    chk("glitch_result_valid", 16'(result_valid), 16'd1);
    press_for(3'b001, 50);
    chk("long_hold_state", 16'(state_o), 16'd0);
    chk("long_hold_rv", 16'(result_valid), 16'd0);

    // Simultaneous next+back in S_B: back wins, alu_b untouched
    press_for(3'b001, 10);
    chk("reenter_b_state", 16'(state_o), 16'd1);
    sw = 16'h05E3;
    press_for(3'b011, 10);
    chk("prio_state", 16'(state_o), 16'd0);
    chk("prio_alu_b", 16'(alu_b), 16'd7);

    // Execute again, then back from S_SHOW and re-execute with op=2
    sw = 16'h0573;
    press_for(3'b001, 10);
    press_for(3'b001, 10);
    exp_q.push_back(mk(4'd3, 4'd7, 3'd5));
    press_for(3'b001, 10);
    chk("second_exec_state", 16'(state_o), 16'd4);
    press_for(3'b010, 10);
    chk("back_show_state", 16'(state_o), 16'd2);
    chk("back_show_rv", 16'(result_valid), 16'd0);
    chk("back_show_a", 16'(alu_a), 16'd3);
    chk("back_show_b", 16'(alu_b), 16'd7);
    sw = 16'h0273;
    exp_q.push_back(mk(4'd3, 4'd7, 3'd2));
    press_for(3'b001, 10);
    chk("reexec_state", 16'(state_o), 16'd4);
    chk("reexec_op", 16'(alu_op), 16'd2);

    // Clear from S_OP
    press_for(3'b010, 10);
    chk("pre_clear_state", 16'(state_o), 16'd2);
    press_for(3'b100, 10);
    chk("clear_state", 16'(state_o), 16'd0);
    chk("clear_a", 16'(alu_a), 16'd0);
    chk("clear_b", 16'(alu_b), 16'd0);
    chk("clear_op", 16'(alu_op), 16'd0);
    chk("clear_rv", 16'(result_valid), 16'd0);
    chk("clear_result_q", 16'(result_q), 16'd0);

    // Reset in S_OP with next held through it
    sw = 16'h0573;
    press_for(3'b001, 10);
    button[0] = 1'b1;
    tick(12);
    chk("held_into_op", 16'(state_o), 16'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_state", 16'(state_o), 16'd0);
    chk("midrst_a", 16'(alu_a), 16'd0);
    chk("midrst_b", 16'(alu_b), 16'd0);
    tick(30);
    chk("held_no_advance", 16'(state_o), 16'd0);
    button[0] = 1'b0;
    tick(12);
    chk("released_no_advance", 16'(state_o), 16'd0);
    press_for(3'b001, 10);
    chk("repress_state", 16'(state_o), 16'd1);
    chk("repress_a", 16'(alu_a), 16'd3);

    tick(2);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
